// File: rtl/uart_pkg.sv
// Definitions shared by the UART blocks: FSM states, oversample ratio and the
// helper that turns a prescale value into a bit time in clock cycles.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 8;
  localparam int unsigned PrescaleW  = 16;
  localparam int unsigned BitCntW    = 19;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  // A prescale of zero would give a zero-length bit, so it is clamped to one.
  function automatic logic [BitCntW-1:0] bit_cycles(input logic [PrescaleW-1:0] prescale);
    logic [BitCntW-1:0] p;
    p = (prescale == '0) ? BitCntW'(1) : BitCntW'(prescale);
    return p * BitCntW'(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// AXI-Stream to UART transmitter: start bit, DATA_WIDTH data bits LSB first, one stop bit.
// All outputs are registered; bit time is latched at the accepting handshake.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [PrescaleW-1:0]  prescale
);

  localparam int unsigned     IdxW    = $clog2(DATA_WIDTH + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [BitCntW-1:0]    bit_time_q, bit_time_d;
  logic [BitCntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  tready_q, tready_d;

  logic                  handshake;
  logic                  bit_done;
  logic [BitCntW-1:0]    bit_new;

  assign handshake = s_axis_tvalid & tready_q;
  assign bit_done  = (cnt_q == '0);
  assign bit_new   = bit_cycles(prescale);

  always_comb begin
    state_d    = state_q;
    bit_time_d = bit_time_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    tready_d   = tready_q;

    unique case (state_q)
      StIdle: begin
        txd_d    = 1'b1;
        busy_d   = 1'b0;
        tready_d = 1'b1;
        if (handshake) begin
          // The start bit is driven on the handshake edge itself.
          state_d    = StStart;
          bit_time_d = bit_new;
          cnt_d      = bit_new - BitCntW'(1);
          shreg_d    = s_axis_tdata;
          idx_d      = '0;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
          tready_d   = 1'b0;
        end
      end

      StStart: begin
        if (bit_done) begin
          state_d = StData;
          cnt_d   = bit_time_q - BitCntW'(1);
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - BitCntW'(1);
        end
      end

      StData: begin
        if (bit_done) begin
          cnt_d = bit_time_q - BitCntW'(1);
          if (idx_q == IdxLast) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - BitCntW'(1);
        end
      end

      StStop: begin
        if (bit_done) begin
          state_d  = StIdle;
          txd_d    = 1'b1;
          busy_d   = 1'b0;
          tready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - BitCntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_time_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_time_q <= bit_time_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      tready_q   <= tready_d;
    end
  end

  assign txd           = txd_q;
  assign busy          = busy_q;
  assign s_axis_tready = tready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level line model compared every cycle,
// plus directed frames decoded by a bit sampler against hand-computed values.
module tb_uart_tx;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          txd;
  logic          busy;
  logic [15:0]   prescale;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .txd          (txd),
    .busy         (busy),
    .prescale     (prescale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Line model: a frame is {stop, data, start}; after the handshake edge the
  // line shows frame bit floor(t / bit_time) for t < 10 * bit_time.
  initial begin : line_model
    logic       m_ready, m_active, pend, prev_rst, exp_txd;
    int         m_t, m_bit, m_len, p_bit;
    logic [9:0] m_frame, p_frame;
    m_ready  = 1'b0;
    m_active = 1'b0;
    pend     = 1'b0;
    prev_rst = 1'b1;
    m_t      = 0;
    m_bit    = 1;
    m_len    = 0;
    p_bit    = 1;
    m_frame  = '1;
    p_frame  = '1;
    @(posedge rst);
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ready  = 1'b0;
        m_active = 1'b0;
        pend     = 1'b0;
        prev_rst = 1'b1;
      end else begin
        if (!prev_rst) begin
          if (pend) begin
            m_active = 1'b1;
            m_ready  = 1'b0;
            m_t      = 0;
            m_bit    = p_bit;
            m_frame  = p_frame;
            m_len    = (DW + 2) * m_bit;
          end else if (m_active) begin
            m_t++;
            if (m_t == m_len) begin
              m_active = 1'b0;
              m_ready  = 1'b1;
            end
          end else begin
            m_ready = 1'b1;
          end
        end
        prev_rst = 1'b0;
        pend     = m_ready && s_axis_tvalid;
        if (pend) begin
          p_bit   = ((prescale == 16'd0) ? 1 : int'(prescale)) * 8;
          p_frame = {1'b1, s_axis_tdata, 1'b0};
        end
      end
      exp_txd = m_active ? m_frame[m_t / m_bit] : 1'b1;
      chk("line_txd", {31'd0, txd}, {31'd0, exp_txd});
      chk("line_busy", {31'd0, busy}, {31'd0, m_active});
      chk("line_tready", {31'd0, s_axis_tready}, {31'd0, m_ready});
    end
  end

  // Call between edges; returns just after the handshake edge N.
  task automatic handshake(input logic [7:0] b, input logic [15:0] p, input logic [15:0] p_after,
                           input bit hold, output int waited);
    s_axis_tdata  = b;
    prescale      = p;
    s_axis_tvalid = 1'b1;
    waited        = 0;
    while (!s_axis_tready && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk($sformatf("hs_%02h_ready_seen", b), {31'd0, s_axis_tready}, 32'd1);
    @(posedge clk);
    waited++;
    #1;
    if (!hold) s_axis_tvalid = 1'b0;
    prescale = p_after;
    chk($sformatf("hs_%02h_tready_fall", b), {31'd0, s_axis_tready}, 32'd0);
    chk($sformatf("hs_%02h_busy_rise", b), {31'd0, busy}, 32'd1);
    chk($sformatf("hs_%02h_start_low", b), {31'd0, txd}, 32'd0);
  endtask

  // Samples each bit at its first, centre and last cycle, then times the frame.
  task automatic finish(input logic [7:0] b, input int bt);
    int         off;
    logic [9:0] fr;
    int         pts[3];
    off = 0;
    fr  = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      pts[0] = bt * k;
      pts[1] = bt * k + bt / 2;
      pts[2] = bt * k + bt - 1;
      for (int j = 0; j < 3; j++) begin
        while (off < pts[j]) begin
          @(posedge clk);
          #1;
          off++;
        end
        chk($sformatf("frame_%02h_bit%0d_pt%0d", b, k, j), {31'd0, txd}, {31'd0, fr[k]});
      end
    end
    while (!s_axis_tready && off < 20 * bt + 100) begin
      @(posedge clk);
      #1;
      off++;
    end
    chk($sformatf("frame_%02h_length", b), off, 10 * bt);
    chk($sformatf("frame_%02h_busy_end", b), {31'd0, busy}, 32'd0);
    chk($sformatf("frame_%02h_idle_high", b), {31'd0, txd}, 32'd1);
  endtask

  task automatic gap2();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stimulus
    int         w;
    logic [7:0] b;
    rst           = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    prescale      = 16'd1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_tready", {31'd0, s_axis_tready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("release_tready_low", {31'd0, s_axis_tready}, 32'd0);
    @(posedge clk);
    #1;
    chk("release_tready_high", {31'd0, s_axis_tready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      b = (i == 0) ? 8'h00 : 8'(1 << (i - 1));
      handshake(b, 16'd1, 16'd1, 1'b0, w);
      finish(b, 8);
      gap2();
    end

    for (int i = 0; i < 9; i++) begin
      b = 8'((1 << i) - 1);
      handshake(b, 16'd1, 16'd1, 1'b0, w);
      finish(b, 8);
    end
    gap2();

    // tvalid stays high through the A5 frame; the next word goes on E+1.
    handshake(8'hA5, 16'd1, 16'd1, 1'b1, w);
    finish(8'hA5, 8);
    handshake(8'h5A, 16'd1, 16'd1, 1'b0, w);
    chk("back_to_back_gap", w, 1);
    finish(8'h5A, 8);
    gap2();

    handshake(8'h3C, 16'd4, 16'd1, 1'b0, w);
    finish(8'h3C, 32);
    gap2();

    handshake(8'h00, 16'd1, 16'd1, 1'b0, w);
    repeat (36) @(posedge clk);
    #1;
    chk("pre_abort_txd", {31'd0, txd}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_txd", {31'd0, txd}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_tready", {31'd0, s_axis_tready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_release_tready_low", {31'd0, s_axis_tready}, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_release_tready_high", {31'd0, s_axis_tready}, 32'd1);
    handshake(8'h55, 16'd1, 16'd1, 1'b0, w);
    finish(8'h55, 8);
    gap2();

    handshake(8'h81, 16'd0, 16'd0, 1'b0, w);
    finish(8'h81, 8);
    gap2();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
